// File: rtl/vc_arbiter_ctrl.sv
// Main-FIFO / virtual-channel / destination controller: thresholds, pop sequencing, VC arbitration and push pipeline.
// Optional round-robin VC arbitration is enabled by defining VC_ARB_ROUND_ROBIN_EN.
module vc_arbiter_ctrl #(
    parameter int DATA_SIZE = 6,
    parameter int THR_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [THR_SIZE-1:0]  afMF_in,
    input  logic [THR_SIZE-1:0]  aeMF_in,
    input  logic [THR_SIZE-1:0]  afVC_in,
    input  logic [THR_SIZE-1:0]  aeVC_in,
    input  logic [THR_SIZE-1:0]  afD_in,
    input  logic [THR_SIZE-1:0]  aeD_in,
    output logic [THR_SIZE-1:0]  afMF_o,
    output logic [THR_SIZE-1:0]  aeMF_o,
    output logic [THR_SIZE-1:0]  afVC_o,
    output logic [THR_SIZE-1:0]  aeVC_o,
    output logic [THR_SIZE-1:0]  afD_o,
    output logic [THR_SIZE-1:0]  aeD_o,
    input  logic                 fifo_empty_main,
    input  logic                 fifo_error_main,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic                 vc0_error,
    input  logic                 vc1_error,
    input  logic                 vc0_pause,
    input  logic                 vc1_pause,
    input  logic [DATA_SIZE-1:0] vc0_head,
    input  logic [DATA_SIZE-1:0] vc1_head,
    input  logic                 d0_pause,
    input  logic                 d1_pause,
    input  logic                 d0_empty,
    input  logic                 d1_empty,
    input  logic                 d0_error,
    input  logic                 d1_error,
    output logic                 pop_main,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d,
    output logic [2:0]           state,
    output logic                 idle_out,
    output logic                 error_out
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic       any_error_s;
    logic       src_empty_s;
    logic       vc0_elig_s;
    logic       vc1_elig_s;
    logic       grant0_s;
    logic       grant1_s;
    logic       unused_s;

    // Destination FIFO empty flags are status-only for this controller.
    assign unused_s    = &{1'b0, d0_empty, d1_empty};
    assign state       = state_r;
    assign any_error_s = fifo_error_main | vc0_error | vc1_error | d0_error | d1_error;
    assign src_empty_s = fifo_empty_main & vc0_empty & vc1_empty;

    // A VC may only pop when the destination named by its head MSB is not paused.
    assign vc0_elig_s = ~vc0_empty & ~(vc0_head[DATA_SIZE-1] ? d1_pause : d0_pause);
    assign vc1_elig_s = ~vc1_empty & ~(vc1_head[DATA_SIZE-1] ? d1_pause : d0_pause);

`ifdef VC_ARB_ROUND_ROBIN_EN
    logic last_grant_r;   // 1: VC1 was granted last, so VC0 is next in line

    // Grant selection: alternate when both VCs compete.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (vc0_elig_s && vc1_elig_s) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = vc0_elig_s;
            grant1_s = vc1_elig_s;
        end
    end

    // Last-grant tracker, updated only when a VC pop is issued.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_grant_r <= 1'b1;
        end else if (pop_vc0) begin
            last_grant_r <= 1'b0;
        end else if (pop_vc1) begin
            last_grant_r <= 1'b1;
        end
    end
`else
    // Grant selection: VC0 has strict priority.
    always_comb begin
        grant0_s = vc0_elig_s;
        grant1_s = vc1_elig_s & ~vc0_elig_s;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; init outranks errors, errors outrank going idle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RESET:  next_state_s = ST_INIT;
            ST_INIT:   next_state_s = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else if (!src_empty_s) begin
                    next_state_s = ST_ACTIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else if (any_error_s) begin
                    next_state_s = ST_ERROR;
                end else if (src_empty_s && !push_d0 && !push_d1) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_ERROR:  next_state_s = init ? ST_INIT : ST_ERROR;
            default:   next_state_s = ST_RESET;
        endcase
    end

    // Combinational pop outputs, only live in ACTIVE.
    always_comb begin
        pop_main = 1'b0;
        pop_vc0  = 1'b0;
        pop_vc1  = 1'b0;
        if (state_r == ST_ACTIVE) begin
            pop_main = ~fifo_empty_main & ~vc0_pause & ~vc1_pause;
            pop_vc0  = grant0_s;
            pop_vc1  = grant1_s;
        end else begin
            pop_main = 1'b0;
            pop_vc0  = 1'b0;
            pop_vc1  = 1'b0;
        end
    end

    // Threshold registers, loaded on every edge that lands in INIT with init high.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            afMF_o <= {THR_SIZE{1'b0}};
            aeMF_o <= {THR_SIZE{1'b0}};
            afVC_o <= {THR_SIZE{1'b0}};
            aeVC_o <= {THR_SIZE{1'b0}};
            afD_o  <= {THR_SIZE{1'b0}};
            aeD_o  <= {THR_SIZE{1'b0}};
        end else if (init && (next_state_s == ST_INIT)) begin
            afMF_o <= afMF_in;
            aeMF_o <= aeMF_in;
            afVC_o <= afVC_in;
            aeVC_o <= aeVC_in;
            afD_o  <= afD_in;
            aeD_o  <= aeD_in;
        end
    end

    // Registered status flags; error is held by the ERROR state and cleared on entering INIT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idle_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            idle_out  <= (next_state_s == ST_IDLE);
            error_out <= (next_state_s == ST_ERROR);
        end
    end

    // One-cycle push pipeline: the popped head word is routed by its MSB.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
            data_d  <= {DATA_SIZE{1'b0}};
        end else if (pop_vc0) begin
            push_d0 <= ~vc0_head[DATA_SIZE-1];
            push_d1 <= vc0_head[DATA_SIZE-1];
            data_d  <= vc0_head;
        end else if (pop_vc1) begin
            push_d0 <= ~vc1_head[DATA_SIZE-1];
            push_d1 <= vc1_head[DATA_SIZE-1];
            data_d  <= vc1_head;
        end else begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
        end
    end

endmodule

// File: doc/vc_arbiter_ctrl.md
Name: vc_arbiter_ctrl

Overview:
- Central controller for the main-FIFO → virtual-channel (VC0/VC1) → destination (D0/D1) datapath.
- Holds the FIFO threshold configuration and sequences main-FIFO pops.
- Arbitrates VC0/VC1 pops into destination FIFOs under per-destination pause backpressure.
- Runs a RESET/INIT/IDLE/ACTIVE/ERROR state machine; errors are sticky.

Parameters:
DATA_SIZE, 6, word width; bit DATA_SIZE-1 of a VC head word selects destination (0→D0, 1→D1)
THR_SIZE, 3, width of each threshold register

Ports:
clk  in  1  clock, all state on rising edge
reset_L  in  1  asynchronous active-low reset
init  in  1  configuration request
afMF_in, aeMF_in, afVC_in, aeVC_in, afD_in, aeD_in  in  THR_SIZE each  threshold values to latch
afMF_o, aeMF_o, afVC_o, aeVC_o, afD_o, aeD_o  out  THR_SIZE each  registered thresholds driven to FIFOs
fifo_empty_main, fifo_error_main  in  1  main FIFO status
vc0_empty, vc1_empty, vc0_error, vc1_error  in  1  VC FIFO status
vc0_pause, vc1_pause  in  1  VC almost-full
vc0_head, vc1_head  in  DATA_SIZE  combinational peek of VC head word
d0_pause, d1_pause, d0_empty, d1_empty, d0_error, d1_error  in  1  destination FIFO status
pop_main  out  1  pop main FIFO (combinational)
pop_vc0, pop_vc1  out  1  pop VC FIFO (combinational, one-hot or zero)
push_d0, push_d1  out  1  push destination (registered)
data_d  out  DATA_SIZE  word to destination (registered)
state  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
idle_out  out  1  high in IDLE
error_out  out  1  sticky error

Behaviour:
- Reset (async, reset_L=0): state=RESET; all thresholds, push_d0/1, data_d, error_out, idle_out = 0.
- Combinational pops are forced 0 outside ACTIVE.
- RESET → INIT unconditionally on the first clock edge after reset release.
- INIT:
  - On every cycle with init=1, latch all *_in values into their *_o registers.
  - init=0 → IDLE.
  - Entering INIT clears error_out.
- IDLE:
  - idle_out=1 is registered in the same cycle; it asserts on the edge that enters IDLE.
  - Leave IDLE → ACTIVE when any of the main, VC0 or VC1 FIFOs is non-empty.
- ACTIVE:
  - Go to IDLE when main, VC0, VC1 and any in-flight push are all empty.
  - Any state (except RESET) → INIT when init=1.
  - Error input (any of the five) → ERROR. This takes precedence over IDLE but not over INIT.
- ERROR:
  - error_out=1; all pops 0; pushes deassert next cycle.
  - Exit only via reset or init=1 (→ INIT).
- pop_main (ACTIVE only): !fifo_empty_main && !vc0_pause && !vc1_pause.
- VC eligibility: VCn is eligible when !vcN_empty and the pause of its destination (vcN_head[DATA_SIZE-1]) is 0.
- Arbitration (default): strict priority; VC0 wins when eligible, else VC1 when eligible, else no pop.
- Push pipeline:
  - Next edge after pop_vcN=1: data_d <= vcN_head; push_dX <= 1 for X = head MSB; the other push is 0.
  - Push latency is exactly 1 cycle; at most one push per cycle.
  - A pause asserting in the push cycle does not cancel the in-flight push; destination almost-full margin absorbs it.
- Simultaneous events:
  - pop_main and a VC pop may both assert in one cycle.
  - When init and an error input are both high, INIT wins.
- Reset mid-operation: any in-flight push is dropped; push outputs go 0 immediately (asynchronous).

Optional Feature:
- Macro: VC_ARB_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last_grant register (reset 1, so VC0 is favoured first) tracks the last VC granted.
  - If both VCs are eligible, grant the VC not granted last.
  - If only one is eligible, grant it; last_grant updates on every grant.
- When undefined: strict VC0 priority, and the last_grant register is not present.

Test Plan:
- Reset then init=1 for 2 cycles with afMF_in=6, aeMF_in=1 → state 0→1; afMF_o=6 and aeMF_o=1 after the first init edge; init=0 → state=2, idle_out=1.
- IDLE, vc0_empty=0, vc0_head=6'b100101, d1_pause=0 → ACTIVE, pop_vc0=1; next cycle push_d1=1, data_d=6'b100101, push_d0=0.
- Both VCs non-empty, heads route to D0, d0_pause=0, macro undefined → pop_vc0 every cycle, pop_vc1=0. With macro defined → pop_vc0/pop_vc1 alternate, starting with VC0.
- vc0_head routes to D0 with d0_pause=1, vc1_head routes to D1 with d1_pause=0 → pop_vc1=1, pop_vc0=0. Also vc1_pause=1 with main non-empty → pop_main=0.
- ACTIVE, pulse vc1_error for 1 cycle → state=4, error_out=1, all pops 0 and held; init=1 → state=1, error_out=0.
- reset_L=0 asynchronously in the cycle after pop_vc0 → push_d0=0 and data_d=0 immediately, state=0; no push after reset release.
